// File: rtl/conv_ctrl.sv
// conv_ctrl: sequencer for the IF_PORT x K_NUM weight-stationary MAC array.
// It loads a kernel set (PREFETCH) and streams one OF_WIDTH x OF_HEIGHT frame
// (CONV). It also follows the array's skewed pipeline to produce per-column
// output strobes and coordinates, and pulses of_done after the last result.
//
// Handshake: a patch transfers on every cycle where if_valid && if_ready.
// if_ready is decoded from registered state only, so the source may safely
// make if_valid depend on if_ready. Weight words have no ready: in PREFETCH
// every k_valid cycle is consumed and shifts the weight chain one stage.
module conv_ctrl #(
    parameter int IF_PORT   = 27,
    parameter int K_NUM     = 3,
    parameter int OF_WIDTH  = 128,
    parameter int OF_HEIGHT = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         k_prefetch,
    input  logic                         k_valid,
    input  logic                         if_start,
    input  logic                         if_valid,
    output logic                         if_ready,
    output logic                         prefetch,
    output logic                         conv,
    output logic [K_NUM-1:0]             of_valid,
    output logic [$clog2(OF_WIDTH)-1:0]  of_x,
    output logic [$clog2(OF_HEIGHT)-1:0] of_y,
    output logic                         busy,
    output logic                         of_done,
    output logic [2:0]                   fsm_state
);

    localparam int N_PIX = OF_WIDTH * OF_HEIGHT;
    localparam int CW    = $clog2(N_PIX + 1);
    localparam int DL    = IF_PORT + K_NUM;
    localparam int WCW   = $clog2(IF_PORT + 1);
    localparam int XW    = $clog2(OF_WIDTH);
    localparam int YW    = $clog2(OF_HEIGHT);
    // The acceptance edge itself is the first delay stage, so the stored
    // line is one stage shorter than the full DL-cycle pipeline.
    localparam int LW    = DL - 1;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_READY    = 3'd2;
    localparam logic [2:0] S_CONV     = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]     state;
    logic [2:0]     state_nxt;
    logic [WCW-1:0] wcnt;
    logic [CW-1:0]  pcnt;
    logic [LW-1:0]  line;
    logic [LW-1:0]  line_nxt;
    logic           accept;

    assign fsm_state = state;
    assign if_ready  = (state == S_CONV);
    assign conv      = (state == S_CONV) || (state == S_DRAIN);
    assign prefetch  = (state == S_PREFETCH) && k_valid;
    assign busy      = (state != S_IDLE) && (state != S_READY);
    assign of_done   = (state == S_DONE);
    assign accept    = if_ready && if_valid;
    assign line_nxt  = (line << 1) | LW'(accept);

    // Column j sees a patch j cycles after column 0 because of the array skew.
    always_comb begin
        of_valid = '0;
        for (int j = 0; j < K_NUM; j++) begin
            of_valid[j] = line[IF_PORT + j - 1];
        end
    end

    // Next-state decode; k_prefetch beats if_start in READY.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (k_prefetch) state_nxt = S_PREFETCH;
            S_PREFETCH: if (k_valid && (wcnt == WCW'(IF_PORT - 1))) state_nxt = S_READY;
            S_READY: begin
                if (k_prefetch)    state_nxt = S_PREFETCH;
                else if (if_start) state_nxt = S_CONV;
            end
            S_CONV:     if (accept && (pcnt == CW'(N_PIX - 1))) state_nxt = S_DRAIN;
            // Leave once the last in-flight strobe has been shifted out.
            S_DRAIN:    if (line_nxt == '0) state_nxt = S_DONE;
            S_DONE:     state_nxt = S_READY;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // State register and valid delay line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            line  <= '0;
        end else begin
            state <= state_nxt;
            line  <= line_nxt;
        end
    end

    // Weight counter: cleared when a (re)load starts, counts accepted words.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wcnt <= '0;
        end else if ((state != S_PREFETCH) && (state_nxt == S_PREFETCH)) begin
            wcnt <= '0;
        end else if ((state == S_PREFETCH) && k_valid) begin
            wcnt <= wcnt + 1'b1;
        end
    end

    // Pixel counter: cleared at frame start, counts accepted patches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcnt <= '0;
        end else if ((state == S_READY) && (state_nxt == S_CONV)) begin
            pcnt <= '0;
        end else if (accept) begin
            pcnt <= pcnt + 1'b1;
        end
    end

    // Output coordinates follow column 0; x wraps into the next row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            of_x <= '0;
            of_y <= '0;
        end else if ((state == S_READY) && (state_nxt == S_CONV)) begin
            of_x <= '0;
            of_y <= '0;
        end else if (of_valid[0]) begin
            if (of_x == XW'(OF_WIDTH - 1)) begin
                of_x <= '0;
                of_y <= (of_y == YW'(OF_HEIGHT - 1)) ? '0 : of_y + 1'b1;
            end else begin
                of_x <= of_x + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl with a 4x2 frame: control table plus frame sequences
// checked against a cycle-stamped pixel queue and an acceptance history.
module tb_conv_ctrl;

    localparam int IF_PORT   = 27;
    localparam int K_NUM     = 3;
    localparam int OF_WIDTH  = 4;
    localparam int OF_HEIGHT = 2;
    localparam int DL        = IF_PORT + K_NUM;
    localparam int HIST      = 4096;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PREFETCH = 3'd1;
    localparam logic [2:0] S_READY    = 3'd2;
    localparam logic [2:0] S_CONV     = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             k_prefetch = 1'b0;
    logic             k_valid = 1'b0;
    logic             if_start = 1'b0;
    logic             if_valid = 1'b0;
    logic             if_ready;
    logic             prefetch;
    logic             conv;
    logic [K_NUM-1:0] of_valid;
    logic [1:0]       of_x;
    logic [0:0]       of_y;
    logic             busy;
    logic             of_done;
    logic [2:0]       fsm_state;

    conv_ctrl #(
        .IF_PORT(IF_PORT), .K_NUM(K_NUM), .OF_WIDTH(OF_WIDTH), .OF_HEIGHT(OF_HEIGHT)
    ) dut (
        .clk(clk), .rst(rst), .k_prefetch(k_prefetch), .k_valid(k_valid),
        .if_start(if_start), .if_valid(if_valid), .if_ready(if_ready),
        .prefetch(prefetch), .conv(conv), .of_valid(of_valid), .of_x(of_x),
        .of_y(of_y), .busy(busy), .of_done(of_done), .fsm_state(fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int tests = 0;
    int failures = 0;
    int cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];  // {cycle[15:0], y[7:0], x[7:0]}
    bit          acc_hist[0:HIST-1];
    int          acc_cnt, first_acc, last_acc, done_cnt, done_cyc, pf_cnt;
    int          exp_x, exp_y;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hist();
        for (int i = 0; i < HIST; i++) acc_hist[i] = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: samples on the falling edge, mid-cycle.
    initial begin
        clear_hist();
        forever begin
            logic [K_NUM-1:0] exp_v;
            logic [31:0]      e;
            @(negedge clk);
            exp_v = '0;
            for (int j = 0; j < K_NUM; j++) begin
                int idx;
                idx = cyc - IF_PORT - j;
                if (idx >= 0 && idx < HIST) exp_v[j] = acc_hist[idx];
            end
            check("of_valid", of_valid, exp_v);
            if (of_valid[0]) begin
                if (exp_q.size() == 0) begin
                    tests = tests + 1;
                    failures = failures + 1;
                    $display("FAIL sb_unexpected: of_valid[0] at cycle %0d, expected no pixel", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pixel", {16'(cyc), 8'(of_y), 8'(of_x)}, e);
                end
            end
            if (of_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (prefetch) pf_cnt = pf_cnt + 1;
            if (rst && if_ready && if_valid) begin
                if (cyc < HIST) acc_hist[cyc] = 1'b1;
                exp_q.push_back({16'(cyc + IF_PORT), 8'(exp_y), 8'(exp_x)});
                if (exp_x == OF_WIDTH - 1) begin
                    exp_x = 0;
                    exp_y = (exp_y == OF_HEIGHT - 1) ? 0 : exp_y + 1;
                end else begin
                    exp_x = exp_x + 1;
                end
                acc_cnt = acc_cnt + 1;
                if (first_acc < 0) first_acc = cyc;
                last_acc = cyc;
            end
        end
    end

    // ---------------- control vector table ----------------
    typedef struct {
        logic       kp, kv, st, iv;
        logic [2:0] s;
        logic       pf, bz, rd, cv;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input logic kp, kv, st, iv, input logic [2:0] s,
                                    input logic pf, bz, rd, cv);
        vec_t v;
        v.kp = kp; v.kv = kv; v.st = st; v.iv = iv; v.s = s;
        v.pf = pf; v.bz = bz; v.rd = rd; v.cv = cv;
        vecs.push_back(v);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic run_frame(input bit alt, input bit kp, input bit hold, input string tag);
        int t0;
        int span;
        acc_cnt = 0; first_acc = -1; last_acc = -1; done_cnt = 0; done_cyc = -1;
        pf_cnt = 0; exp_x = 0; exp_y = 0;
        if_start = 1'b1;
        if_valid = 1'b0;
        step();
        t0 = cyc;
        check({tag, "_conv_entry"}, {fsm_state, if_ready, conv, busy}, {S_CONV, 3'b111});
        if (!hold) if_start = 1'b0;
        for (int k = 0; k < 150 && done_cnt == 0; k++) begin
            if_valid   = alt ? ((k % 2) == 0) : 1'b1;
            k_prefetch = kp && (k < 20);
            step();
        end
        if_valid   = 1'b0;
        k_prefetch = 1'b0;
        span = alt ? 14 : 7;
        check({tag, "_done_count"}, done_cnt, 1);
        check({tag, "_accept_count"}, acc_cnt, 8);
        check({tag, "_first_accept"}, first_acc, t0);
        check({tag, "_last_accept"}, last_acc, t0 + span);
        check({tag, "_done_cycle"}, done_cyc, t0 + span + DL);
        check({tag, "_prefetch_pulses"}, pf_cnt, 0);
        check({tag, "_after_done"}, {fsm_state, busy}, {S_READY, 1'b0});
        check({tag, "_sb_drained"}, exp_q.size(), 0);
        step();
        if (hold) begin
            check({tag, "_b2b_start"}, {fsm_state, if_ready}, {S_CONV, 1'b1});
            if_start = 1'b0;
            acc_cnt = 0; first_acc = -1; exp_x = 0; exp_y = 0;
        end else begin
            check({tag, "_done_single"}, done_cnt, 1);
        end
    endtask

    task automatic prefetch_words(input int n);
        pf_cnt = 0;
        k_prefetch = 1'b1;
        step();
        k_prefetch = 1'b0;
        for (int i = 0; i < n; i++) begin
            k_valid = 1'b1;
            step();
        end
        k_valid = 1'b0;
        check("reload_ready", {fsm_state, busy}, {S_READY, 1'b0});
        check("reload_pulses", pf_cnt, n);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        acc_cnt = 0; first_acc = -1; last_acc = -1; done_cnt = 0; done_cyc = -1;
        pf_cnt = 0; exp_x = 0; exp_y = 0;
        repeat (3) step();
        check("reset_values",
              {if_ready, prefetch, conv, of_valid, of_x, of_y, busy, of_done, fsm_state}, '0);
        rst = 1'b1;
        step();

        // Inputs applied for one cycle; expectations are the outputs in that cycle.
        add_vec(0, 0, 1, 0, S_IDLE, 0, 0, 0, 0);
        add_vec(0, 0, 1, 1, S_IDLE, 0, 0, 0, 0);
        add_vec(1, 0, 0, 0, S_IDLE, 0, 0, 0, 0);
        for (int i = 0; i < IF_PORT; i++) begin
            add_vec(0, 1, 0, 0, S_PREFETCH, 1, 1, 0, 0);
            if (i < IF_PORT - 1) add_vec(1, 0, 1, 1, S_PREFETCH, 0, 1, 0, 0);
        end
        add_vec(0, 1, 0, 0, S_READY, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, S_READY, 0, 0, 0, 0);
        add_vec(1, 0, 1, 0, S_READY, 0, 0, 0, 0);
        add_vec(0, 0, 0, 0, S_PREFETCH, 0, 1, 0, 0);
        for (int i = 0; i < IF_PORT; i++) add_vec(0, 1, 0, 0, S_PREFETCH, 1, 1, 0, 0);
        add_vec(0, 0, 0, 0, S_READY, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            k_prefetch = vecs[i].kp;
            k_valid    = vecs[i].kv;
            if_start   = vecs[i].st;
            if_valid   = vecs[i].iv;
            #2;
            check($sformatf("vec%0d", i),
                  {fsm_state, prefetch, busy, if_ready, conv},
                  {vecs[i].s, vecs[i].pf, vecs[i].bz, vecs[i].rd, vecs[i].cv});
            step();
        end
        k_prefetch = 1'b0; k_valid = 1'b0; if_start = 1'b0; if_valid = 1'b0;
        step();

        run_frame(1'b0, 1'b0, 1'b0, "full");
        run_frame(1'b1, 1'b1, 1'b0, "bubble");
        run_frame(1'b0, 1'b0, 1'b1, "b2b");

        // Reset in the middle of the second back-to-back frame.
        if_valid = 1'b1;
        for (int k = 0; k < 20 && acc_cnt < 3; k++) step();
        check("midreset_accepts", acc_cnt, 3);
        rst = 1'b0;
        #1;
        check("midreset_outputs",
              {if_ready, prefetch, conv, of_valid, of_x, of_y, busy, of_done, fsm_state}, '0);
        clear_hist();
        if_valid = 1'b0;
        done_cnt = 0;
        acc_cnt = 0;
        step();
        step();
        rst = 1'b1;
        if_start = 1'b1;
        if_valid = 1'b1;
        repeat (4) step();
        check("idle_ignores_start", {fsm_state, if_ready, busy}, {S_IDLE, 2'b00});
        check("midreset_no_done", done_cnt, 0);
        check("midreset_no_accept", acc_cnt, 0);
        if_start = 1'b0;
        if_valid = 1'b0;
        step();

        prefetch_words(IF_PORT);
        run_frame(1'b0, 1'b0, 1'b0, "reuse_a");
        run_frame(1'b0, 1'b0, 1'b0, "reuse_b");

        repeat (3) step();
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
